// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter with a small write FIFO in front of it.
// Frames are sent LSB first: start bit (0), DATA_BITS data bits, an optional
// parity bit, then STOP_BITS stop bits (1). Queued words go out back-to-back,
// the next start bit directly following the previous stop bit.
//
// Optional feature: define UART_TX_PARITY_EN to add the parity bit
// (even parity for PARITY_ODD=0, odd parity for PARITY_ODD=1). Without the
// macro there is no parity state and no parity logic at all.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (aborts any frame, drops queue)
//   trmt       in   push strobe, tx_data captured when trmt=1 and fifo_full=0
//   tx_data    in   [DATA_BITS-1:0] word to transmit
//   fifo_full  out  FIFO holds FIFO_DEPTH words
//   overrun    out  one-cycle pulse for a push attempted while full (word dropped)
//   tx_done    out  one-cycle pulse during the last clk of a frame's final stop bit
//   tx_idle    out  1 when nothing is queued and no frame is in progress
//   TX         out  serial line, idles high, driven from a register
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 fifo_full,
    output logic                 overrun,
    output logic                 tx_done,
    output logic                 tx_idle,
    output logic                 TX
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for one data word: XOR of the data, inverted for odd parity.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
        logic p;
        p = ^data;
        return (PARITY_ODD != 0) ? ~p : p;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_next_s;
    logic                 fifo_full_r;
    logic                 overrun_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic [DATA_BITS-1:0] head_s;

    // Transmitter state
    state_t               state_r;
    state_t               state_next_s;
    logic [BAUD_W-1:0]    baud_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 bit_tick_s;
    logic                 done_s;
    logic                 tx_r;
    logic                 tx_done_r;
    logic                 tx_idle_r;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
`endif

    // A push is accepted only when not full; a pop in the same cycle does not
    // make room for it.
    assign push_s     = trmt & ~fifo_full_r;
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign head_s     = mem_r[rd_ptr_r];
    assign bit_tick_s = (baud_cnt_r == BAUD_LAST);

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO data storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers, occupancy, full flag (from next count) and overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            fifo_full_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_next_s;
            fifo_full_r <= (count_next_s == CNT_FULL);
            overrun_r   <= trmt & fifo_full_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state, FIFO pop and end-of-frame strobe.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s && (bit_cnt_r == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s && (bit_cnt_r == STOP_LAST)) begin
                    done_s = 1'b1;
                    // Chain straight into the next frame when data is waiting.
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Baud counter, bit counter, shift register and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            // Exact wrap at BAUD_DIV-1 keeps every bit BAUD_DIV clks long.
            if ((state_r == ST_IDLE) || bit_tick_s) begin
                baud_cnt_r <= {BAUD_W{1'b0}};
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
            end

            // Bit counter restarts on every state change.
            if (state_next_s != state_r) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (bit_tick_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end

            if (pop_s) begin
                shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                parity_r <= parity_of(head_s);
`endif
            end else if ((state_r == ST_DATA) && bit_tick_s) begin
                shift_r <= shift_r >> 1;
            end
        end
    end

    // Registered line and status outputs. TX follows the state one clk later,
    // which gives the two-edge push-to-start latency and uniform bit widths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r      <= 1'b1;
            tx_done_r <= 1'b0;
            tx_idle_r <= 1'b1;
        end else begin
            case (state_r)
                ST_START:  tx_r <= 1'b0;
                ST_DATA:   tx_r <= shift_r[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: tx_r <= parity_r;
`endif
                default:   tx_r <= 1'b1;
            endcase
            tx_done_r <= done_s;
            tx_idle_r <= (state_r == ST_IDLE) & empty_s & ~push_s;
        end
    end

    assign fifo_full = fifo_full_r;
    assign overrun   = overrun_r;
    assign tx_done   = tx_done_r;
    assign tx_idle   = tx_idle_r;
    assign TX        = tx_r;

endmodule
